uart_rx_byte: RTL and testbench

UART_RX_BYTE -- requirements
Module: uart_rx_byte

---
 rtl/uart_rx_byte.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
`timescale 1ns/1ps
// UART receiver: 8 data bits, LSB first, 1 stop bit, mid-bit sampling, break detection.
// Optional even-parity bit after bit 7 when UART_RX_PARITY_EN is defined.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Frame_Err,
    output logic       o_RX_Parity_Err
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT - 1) / 2);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } state_t;

    // Even parity: the parity bit equals the XOR of the data bits.
    function automatic logic even_parity_f(input logic [7:0] data);
        return ^data;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } state_t;
`endif

    state_t      state_r, state_s;
    logic        sync_meta_r, sync_r;
    logic [15:0] clk_cnt_r, clk_cnt_s;
    logic [2:0]  bit_idx_r, bit_idx_s;
    logic [7:0]  shift_r, shift_s;
    logic [7:0]  byte_r, byte_s;
    logic        dv_r, dv_s;
    logic        ferr_r, ferr_s;
`ifdef UART_RX_PARITY_EN
    logic        parity_r, parity_s;
    logic        perr_r, perr_s;
`endif

    // Two-flop synchronizer, FSM state and datapath registers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_meta_r <= 1'b1;
            sync_r      <= 1'b1;
            state_r     <= IDLE;
            clk_cnt_r   <= 16'd0;
            bit_idx_r   <= 3'd0;
            shift_r     <= 8'h00;
            byte_r      <= 8'h00;
            dv_r        <= 1'b0;
            ferr_r      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_r    <= 1'b0;
            perr_r      <= 1'b0;
`endif
        end else begin
            sync_meta_r <= i_RX_Serial;
            sync_r      <= sync_meta_r;
            state_r     <= state_s;
            clk_cnt_r   <= clk_cnt_s;
            bit_idx_r   <= bit_idx_s;
            shift_r     <= shift_s;
            byte_r      <= byte_s;
            dv_r        <= dv_s;
            ferr_r      <= ferr_s;
`ifdef UART_RX_PARITY_EN
            parity_r    <= parity_s;
            perr_r      <= perr_s;
`endif
        end
    end

    // Next-state and next-datapath logic; pulses default low every cycle.
    always_comb begin
        state_s   = state_r;
        clk_cnt_s = clk_cnt_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        byte_s    = byte_r;
        dv_s      = 1'b0;
        ferr_s    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_s  = parity_r;
        perr_s    = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                clk_cnt_s = 16'd0;
                bit_idx_s = 3'd0;
                if (!sync_r) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (clk_cnt_r == HALF_LAST) begin
                    clk_cnt_s = 16'd0;
                    if (!sync_r) begin
                        state_s = DATA;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + 16'd1;
                end
            end
            DATA: begin
                if (clk_cnt_r == BIT_LAST) begin
                    clk_cnt_s = 16'd0;
                    shift_s   = {sync_r, shift_r[7:1]};
                    bit_idx_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_s = PARITY;
`else
                        state_s = STOP;
`endif
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_cnt_r == BIT_LAST) begin
                    clk_cnt_s = 16'd0;
                    parity_s  = sync_r;
                    state_s   = STOP;
                end else begin
                    clk_cnt_s = clk_cnt_r + 16'd1;
                end
            end
`endif
            STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
                if (clk_cnt_r == BIT_LAST) begin
                    clk_cnt_s = 16'd0;
                    if (sync_r) begin
                        state_s = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (even_parity_f(shift_r) != parity_r) begin
                            perr_s = 1'b1;
                        end else begin
                            byte_s = shift_r;
                            dv_s   = 1'b1;
                        end
`else
                        byte_s = shift_r;
                        dv_s   = 1'b1;
`endif
                    end else begin
                        ferr_s  = 1'b1;
                        state_s = BREAK_WAIT;
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + 16'd1;
                end
            end
            BREAK_WAIT: begin
                if (sync_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = BREAK_WAIT;
                end
            end
            default: begin
                state_s   = IDLE;
                clk_cnt_s = 16'd0;
                bit_idx_s = 3'd0;
            end
        endcase
    end

    assign o_RX_DV        = dv_r;
    assign o_RX_Byte      = byte_r;
    assign o_RX_Frame_Err = ferr_r;
`ifdef UART_RX_PARITY_EN
    assign o_RX_Parity_Err = perr_r;
`else
    assign o_RX_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx_byte: directed frames plus randomized frames
// against a frame-level reference model (expected bytes / error counts).
module tb_uart_rx_byte;

    localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       dv;
    logic [7:0] byte_o;
    logic       ferr;
    logic       perr;

    int tests = 0;
    int fails = 0;
    int dv_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int viol_cnt = 0;
    logic prev_any = 1'b0;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clk           (clk),
        .i_Rst_L         (rst_n),
        .i_RX_Serial     (rx),
        .o_RX_DV         (dv),
        .o_RX_Byte       (byte_o),
        .o_RX_Frame_Err  (ferr),
        .o_RX_Parity_Err (perr)
    );

    // Pulse monitor: counts pulses, logs delivered bytes, flags overlap or back-to-back pulses.
    always @(negedge clk) begin
        if (dv) begin
            dv_cnt <= dv_cnt + 1;
            rx_q.push_back(byte_o);
        end
        if (ferr) ferr_cnt <= ferr_cnt + 1;
        if (perr) perr_cnt <= perr_cnt + 1;
        if ((int'(dv) + int'(ferr) + int'(perr)) > 1) viol_cnt <= viol_cnt + 1;
        else if ((dv || ferr || perr) && prev_any) viol_cnt <= viol_cnt + 1;
        prev_any <= dv || ferr || perr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_err);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR_EN) send_bit((^d) ^ par_err);
        send_bit(stop_bit);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    int b_dv, b_fe, b_pe;
    int exp_ferr, exp_perr, exp_perr_total;
    logic [7:0] exp_q[$];

    initial begin
        exp_perr_total = 0;
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_byte", 32'(byte_o), 32'h00);
        check("rst_dv", 32'(dv), 32'd0);
        check("rst_ferr", 32'(ferr), 32'd0);
        check("rst_perr", 32'(perr), 32'd0);
        rst_n = 1'b1;
        idle(4);

        // Single good frame
        b_dv = dv_cnt; b_fe = ferr_cnt; b_pe = perr_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(4);
        check("a5_dv_cnt", 32'(dv_cnt - b_dv), 32'd1);
        check("a5_byte", 32'(byte_o), 32'hA5);
        check("a5_ferr", 32'(ferr_cnt - b_fe), 32'd0);
        check("a5_perr", 32'(perr_cnt - b_pe), 32'd0);

        // Back-to-back frames, zero idle
        rx_q.delete();
        b_dv = dv_cnt;
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        idle(4);
        check("b2b_dv_cnt", 32'(dv_cnt - b_dv), 32'd2);
        check("b2b_first", 32'(rx_q[0]), 32'h3C);
        check("b2b_second", 32'(rx_q[1]), 32'hC3);
        check("b2b_byte", 32'(byte_o), 32'hC3);

        // Two-cycle low glitch on idle line
        b_dv = dv_cnt; b_fe = ferr_cnt; b_pe = perr_cnt;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        idle(30);
        check("glitch_dv", 32'(dv_cnt - b_dv), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - b_fe), 32'd0);
        check("glitch_perr", 32'(perr_cnt - b_pe), 32'd0);
        check("glitch_byte", 32'(byte_o), 32'hC3);

        // Bad stop bit followed by a 100-cycle break
        b_dv = dv_cnt; b_fe = ferr_cnt; b_pe = perr_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        idle(16);
        check("brk_ferr", 32'(ferr_cnt - b_fe), 32'd1);
        check("brk_dv", 32'(dv_cnt - b_dv), 32'd0);
        check("brk_perr", 32'(perr_cnt - b_pe), 32'd0);
        check("brk_byte", 32'(byte_o), 32'hC3);
        b_dv = dv_cnt;
        send_frame(8'h12, 1'b1, 1'b0);
        idle(4);
        check("after_brk_dv", 32'(dv_cnt - b_dv), 32'd1);
        check("after_brk_byte", 32'(byte_o), 32'h12);

`ifdef UART_RX_PARITY_EN
        // Wrong parity, then correct parity
        b_dv = dv_cnt; b_pe = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(4);
        exp_perr_total = exp_perr_total + 1;
        check("par_bad_perr", 32'(perr_cnt - b_pe), 32'd1);
        check("par_bad_dv", 32'(dv_cnt - b_dv), 32'd0);
        check("par_bad_byte", 32'(byte_o), 32'h12);
        b_dv = dv_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        idle(4);
        check("par_ok_dv", 32'(dv_cnt - b_dv), 32'd1);
        check("par_ok_byte", 32'(byte_o), 32'h07);
`endif

        // Reset during data bit 4 of 0xFF
        b_dv = dv_cnt; b_fe = ferr_cnt; b_pe = perr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_byte", 32'(byte_o), 32'h00);
        check("midrst_dv", 32'(dv), 32'd0);
        check("midrst_ferr", 32'(ferr), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(6 * CPB);
        check("midrst_no_dv", 32'(dv_cnt - b_dv), 32'd0);
        check("midrst_no_ferr", 32'(ferr_cnt - b_fe), 32'd0);
        check("midrst_no_perr", 32'(perr_cnt - b_pe), 32'd0);
        b_dv = dv_cnt;
        send_frame(8'h81, 1'b1, 1'b0);
        idle(4);
        check("post_rst_dv", 32'(dv_cnt - b_dv), 32'd1);
        check("post_rst_byte", 32'(byte_o), 32'h81);

        // Randomized frames against the frame-level model
        rx_q.delete();
        exp_q.delete();
        exp_ferr = 0; exp_perr = 0;
        b_dv = dv_cnt; b_fe = ferr_cnt; b_pe = perr_cnt;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic       stop_bad;
            logic       par_err;
            int         gap;
            d        = 8'($urandom_range(0, 255));
            stop_bad = ($urandom_range(0, 4) == 0);
            par_err  = ($urandom_range(0, 3) == 0);
            gap      = $urandom_range(0, 2);
            if (stop_bad && gap == 0) gap = 1;
            send_frame(d, !stop_bad, par_err);
            idle(gap * CPB);
            if (stop_bad) exp_ferr++;
            else if (PAR_EN && par_err) exp_perr++;
            else exp_q.push_back(d);
        end
        idle(20);
        exp_perr_total = exp_perr_total + exp_perr;
        check("rnd_dv_cnt", 32'(dv_cnt - b_dv), 32'(exp_q.size()));
        check("rnd_ferr_cnt", 32'(ferr_cnt - b_fe), 32'(exp_ferr));
        check("rnd_perr_cnt", 32'(perr_cnt - b_pe), 32'(exp_perr));
        check("rnd_q_size", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("rnd_byte_%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        end

        check("pulse_exclusive", 32'(viol_cnt), 32'd0);
        check("perr_total", 32'(perr_cnt), 32'(exp_perr_total));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
